mem_stage_sram: RTL and testbench
=================================

Name: mem_stage_sram

Overview:
- Memory stage of the 5-stage ARM pipeline. Sits directly downstream of the EXE/MEM pipeline register and consumes its outputs (wb_en, mem_r_en, mem_w_en, alu_result, val_rm, dest).
- Performs loads and stores against an external single-port, fixed-latency SRAM, using an FSM and a wait-state counter.
- Drives a pipeline freeze while an access is in flight.
- Contains the MEM/WB pipeline register that feeds write-back.

Parameters:
- BIT_NUMBER, 32: datapath width.
- ADDR_W, 16: SRAM word-address width.
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- WAIT_CYCLES, 4: SRAM access latency in cycles; legal range 1..15.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- wb_en_in  in  1  write-back enable from EXE/MEM register
- mem_r_en_in  in  1  load request
- mem_w_en_in  in  1  store request
- alu_result_in  in  BIT_NUMBER  effective byte address, or ALU result
- val_rm_in  in  BIT_NUMBER  store data
- dest_in  in  4  destination register
- sram_rdata  in  BIT_NUMBER  SRAM read data, valid on the last wait cycle
- sram_addr  out  ADDR_W  SRAM word address
- sram_wdata  out  BIT_NUMBER  SRAM write data
- sram_we  out  1  SRAM write strobe
- sram_en  out  1  SRAM chip enable
- freeze  out  1  stall of PC, IF/ID, ID/EXE and EXE/MEM registers
- wb_en  out  1  MEM/WB write-back enable
- mem_r_en  out  1  MEM/WB select: load data vs ALU result
- alu_result  out  BIT_NUMBER  MEM/WB ALU result
- mem_data  out  BIT_NUMBER  MEM/WB load data
- dest  out  4  MEM/WB destination register
- align_err  out  1  sticky misalignment flag (see Optional Feature)

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; counter goes to 0.
  - All MEM/WB outputs go to 0, and sram_we=0, sram_en=0, align_err=0.
  - A reset mid-access abandons the access; no partial write may complete after rst deasserts.
- Request: req = mem_r_en_in | mem_w_en_in. If both are set, the access is a store; the load is ignored and mem_r_en is registered as 0.
- Address: sram_addr = (alu_result_in - BASE_ADDR) >> 2, truncated to ADDR_W bits. Wrap-around is silent. sram_wdata = val_rm_in.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: if req, go to BUSY and load counter with WAIT_CYCLES-1; otherwise stay in IDLE.
  - BUSY: sram_en=1 and sram_we=mem_w_en_in, for exactly WAIT_CYCLES cycles. The counter decrements each cycle. At counter==0, sram_rdata is captured into an internal buffer and the FSM goes to DONE.
  - DONE: sram_en=0. Always returns to IDLE next cycle.
- freeze = req & (state != DONE). This is combinational.
  - A memory op stalls upstream for WAIT_CYCLES+1 cycles.
  - A non-memory op never stalls.
- MEM/WB register, on posedge clk:
  - When freeze=0: capture wb_en_in, the load flag, alu_result_in, dest_in, and mem_data (buffered SRAM data for a load, otherwise hold the previous value).
  - When freeze=1: insert a bubble (wb_en<=0, mem_r_en<=0); alu_result, dest and mem_data hold.
- Back-to-back memory ops: the second op is seen in IDLE on the cycle after DONE. There is no combining.
- Inputs are held stable by upstream while freeze=1. The block does not re-register them.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - A request with alu_result_in[1:0] != 0 sets align_err, which stays set until reset.
  - sram_we stays 0 for a misaligned store; the FSM still runs its full sequence so that timing is unchanged.
  - A misaligned load returns 0 in mem_data.
- Undefined: low address bits are ignored, align_err is tied to 0, and there is no write suppression.

Test Plan:
- Reset with a load in flight: after 2 BUSY cycles drive rst=0 → sram_en=0 and freeze=0 immediately, all outputs 0; after rst=1 the FSM is in IDLE.
- ALU op: alu_result_in=0x55, wb_en_in=1, dest_in=3, no req → freeze never asserts; next edge gives wb_en=1, alu_result=0x55, dest=3.
- Store, WAIT_CYCLES=4: mem_w_en_in=1, alu_result_in=1032, val_rm_in=0xDEADBEEF → sram_addr=2 and sram_we=1 for 4 cycles; freeze high for 5 cycles; wb_en=0 bubbles throughout.
- Load: mem_r_en_in=1, alu_result_in=1036, SRAM word 3 = 0x12345678 → after 5 frozen cycles, MEM/WB gives mem_r_en=1, mem_data=0x12345678, dest=dest_in.
- Back-to-back store→load to address 1024 → 10 frozen cycles total; the load returns the stored value.
- MEM_ALIGN_CHECK_EN defined, store to 1026 → align_err=1 and stays 1, sram_we stays 0, freeze still lasts 5 cycles; without the macro align_err=0 and the write goes to word 0.

Source files
------------

// File: rtl/mem_stage_sram_if.sv
// mem_stage_sram_if: EXE/MEM inputs, SRAM port, freeze and MEM/WB outputs of the memory stage.
// The master side is the pipeline/SRAM environment and the slave side is the memory stage.
interface mem_stage_sram_if #(
    parameter int BIT_NUMBER = 32,
    parameter int ADDR_W     = 16
) ();
    logic                  wb_en_in;
    logic                  mem_r_en_in;
    logic                  mem_w_en_in;
    logic [BIT_NUMBER-1:0] alu_result_in;
    logic [BIT_NUMBER-1:0] val_rm_in;
    logic [3:0]            dest_in;
    logic [BIT_NUMBER-1:0] sram_rdata;
    logic [ADDR_W-1:0]     sram_addr;
    logic [BIT_NUMBER-1:0] sram_wdata;
    logic                  sram_we;
    logic                  sram_en;
    logic                  freeze;
    logic                  wb_en;
    logic                  mem_r_en;
    logic [BIT_NUMBER-1:0] alu_result;
    logic [BIT_NUMBER-1:0] mem_data;
    logic [3:0]            dest;
    logic                  align_err;

    modport master (
        output wb_en_in, mem_r_en_in, mem_w_en_in, alu_result_in, val_rm_in, dest_in, sram_rdata,
        input  sram_addr, sram_wdata, sram_we, sram_en, freeze,
        input  wb_en, mem_r_en, alu_result, mem_data, dest, align_err
    );

    modport slave (
        input  wb_en_in, mem_r_en_in, mem_w_en_in, alu_result_in, val_rm_in, dest_in, sram_rdata,
        output sram_addr, sram_wdata, sram_we, sram_en, freeze,
        output wb_en, mem_r_en, alu_result, mem_data, dest, align_err
    );
endinterface

// File: rtl/mem_stage_sram.sv
// mem_stage_sram: ARM pipeline memory stage with fixed-latency SRAM FSM and MEM/WB register.
// Optional misaligned-access detection and store suppression under MEM_ALIGN_CHECK_EN.
module mem_stage_sram #(
    parameter int BIT_NUMBER  = 32,
    parameter int ADDR_W      = 16,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 4
) (
    input logic             clk,
    input logic             rst,
    mem_stage_sram_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                r_state, w_next;
    logic [3:0]            r_cnt;
    logic [BIT_NUMBER-1:0] r_rbuf;
    logic                  r_align_err;
    logic                  r_wb_en, r_mem_r_en;
    logic [BIT_NUMBER-1:0] r_alu_result, r_mem_data;
    logic [3:0]            r_dest;
    logic                  w_req, w_load, w_mis;

    assign w_req  = bus.mem_r_en_in | bus.mem_w_en_in;
    assign w_load = bus.mem_r_en_in & ~bus.mem_w_en_in;
`ifdef MEM_ALIGN_CHECK_EN
    assign w_mis = w_req & (bus.alu_result_in[1:0] != 2'b00);
`else
    assign w_mis = 1'b0;
`endif

    assign bus.sram_addr  = ADDR_W'((bus.alu_result_in - BIT_NUMBER'(BASE_ADDR)) >> 2);
    assign bus.sram_wdata = bus.val_rm_in;
    assign bus.sram_en    = r_state == BUSY;
    assign bus.sram_we    = (r_state == BUSY) & bus.mem_w_en_in & ~w_mis;
    // Gated by rst so the stall drops the moment an access is abandoned.
    assign bus.freeze     = rst & w_req & (r_state != DONE);
    assign bus.align_err  = r_align_err;
    assign bus.wb_en      = r_wb_en;
    assign bus.mem_r_en   = r_mem_r_en;
    assign bus.alu_result = r_alu_result;
    assign bus.mem_data   = r_mem_data;
    assign bus.dest       = r_dest;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_req ? BUSY : IDLE;
            BUSY:    w_next = (r_cnt == 4'd0) ? DONE : BUSY;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_rbuf      <= '0;
            r_align_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_req)
                r_cnt <= 4'(WAIT_CYCLES - 1);
            else if (r_state == BUSY && r_cnt != 4'd0)
                r_cnt <= r_cnt - 4'd1;
            if (r_state == BUSY && r_cnt == 4'd0)
                r_rbuf <= w_mis ? '0 : bus.sram_rdata;
            if (w_mis)
                r_align_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb_en      <= 1'b0;
            r_mem_r_en   <= 1'b0;
            r_alu_result <= '0;
            r_mem_data   <= '0;
            r_dest       <= 4'd0;
        end else if (bus.freeze) begin
            r_wb_en    <= 1'b0;
            r_mem_r_en <= 1'b0;
        end else begin
            r_wb_en      <= bus.wb_en_in;
            r_mem_r_en   <= w_load;
            r_alu_result <= bus.alu_result_in;
            r_dest       <= bus.dest_in;
            if (w_load)
                r_mem_data <= r_rbuf;
        end
    end
endmodule

// File: tb/tb_mem_stage_sram.sv
// tb_mem_stage_sram: scoreboard bench for mem_stage_sram with a transaction-level reference model.
// Honours MEM_ALIGN_CHECK_EN so expectations follow the build being simulated.
module tb_mem_stage_sram;
    localparam int BN = 32, AW = 16, BASE = 1024, WAIT = 4;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    typedef struct packed {
        logic        wb;
        logic        mr;
        logic [31:0] alu;
        logic [3:0]  dest;
        logic [31:0] md;
    } wbrec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_stage_sram_if #(.BIT_NUMBER(BN), .ADDR_W(AW)) ifc ();
    mem_stage_sram #(.BIT_NUMBER(BN), .ADDR_W(AW), .BASE_ADDR(BASE), .WAIT_CYCLES(WAIT))
        dut (.clk(clk), .rst(rst), .bus(ifc));

    int          checks = 0, failures = 0;
    wbrec_t      exp_q[$];
    bit          mon_on = 1'b0;
    logic [31:0] ref_mem [65536];
    logic [31:0] ref_md = '0;
    logic        ref_align = 1'b0;

    function automatic logic [31:0] dflt(int unsigned a);
        return (a == 3) ? 32'h1234_5678 : {16'hA5A5, a[15:0]};
    endfunction

    // SRAM model: unwritten words read back a per-address default
    logic [31:0] sram_w [65536];
    bit          sram_v [65536];
    assign ifc.sram_rdata = sram_v[ifc.sram_addr] ? sram_w[ifc.sram_addr] : dflt(32'(ifc.sram_addr));
    always @(posedge clk)
        if (ifc.sram_en && ifc.sram_we) begin
            sram_w[ifc.sram_addr] <= ifc.sram_wdata;
            sram_v[ifc.sram_addr] <= 1'b1;
        end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(logic wb, logic r, logic w, logic [31:0] alu, logic [31:0] rm, logic [3:0] d);
        ifc.wb_en_in = wb;
        ifc.mem_r_en_in = r;
        ifc.mem_w_en_in = w;
        ifc.alu_result_in = alu;
        ifc.val_rm_in = rm;
        ifc.dest_in = d;
    endtask

    // Monitor: a capture happened at the edge between two negedges if freeze was low at the first
    initial begin
        bit     armed = 1'b0, f_prev = 1'b1;
        wbrec_t e;
        forever begin
            @(negedge clk);
            if (armed && !f_prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL capture: got an unexpected MEM/WB capture, required none");
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_en", ifc.wb_en, e.wb);
                    chk("mem_r_en", ifc.mem_r_en, e.mr);
                    chk("alu_result", ifc.alu_result, e.alu);
                    chk("dest", ifc.dest, e.dest);
                    chk("mem_data", ifc.mem_data, e.md);
                end
            end
            f_prev = ifc.freeze;
            armed = mon_on;
        end
    end

    task automatic issue(logic wb, logic r, logic w, logic [31:0] alu, logic [31:0] rm, logic [3:0] d);
        logic        mem  = r | w;
        logic        load = r & ~w;
        logic        mis  = ALIGN && mem && (alu % 4 != 0);
        int unsigned wa   = ((alu - BASE) / 4) % 65536;
        int          fz = 0, en = 0, we = 0, bad_addr = 0, bub = 0;
        @(posedge clk);
        #1;
        drive(wb, r, w, alu, rm, d);
        mon_on = 1'b1;
        if (w && !mis) ref_mem[wa] = rm;
        if (load) ref_md = mis ? 32'd0 : ref_mem[wa];
        if (mis) ref_align = 1'b1;
        exp_q.push_back('{wb, load, alu, d, ref_md});
        while (fz <= 40) begin
            @(negedge clk);
            if (fz > 0 && ifc.wb_en) bub++;
            if (!ifc.freeze) break;
            fz++;
            if (ifc.sram_en) begin
                en++;
                if (ifc.sram_we) we++;
                if (32'(ifc.sram_addr) != wa) bad_addr++;
            end
        end
        chk("freeze_cycles", fz, mem ? WAIT + 1 : 0);
        chk("sram_en_cycles", en, mem ? WAIT : 0);
        chk("sram_we_cycles", we, (w && !mis) ? WAIT : 0);
        chk("bubble_wb_en", bub, 0);
        if (mem) chk("sram_addr", bad_addr, 0);
        chk("align_err", ifc.align_err, ref_align);
    endtask

    task automatic finish_seq();
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0);
        mon_on = 1'b0;
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ref_mem[i] = dflt(i);
        drive(0, 0, 0, 0, 0, 0);
        #12;
        chk("rst_wb_en", ifc.wb_en, 0);
        chk("rst_mem_r_en", ifc.mem_r_en, 0);
        chk("rst_alu_result", ifc.alu_result, 0);
        chk("rst_mem_data", ifc.mem_data, 0);
        chk("rst_dest", ifc.dest, 0);
        chk("rst_sram_en_we", {ifc.sram_en, ifc.sram_we}, 0);
        chk("rst_freeze", ifc.freeze, 0);
        chk("rst_align_err", ifc.align_err, 0);
        @(negedge clk);
        rst = 1'b1;

        issue(1, 0, 0, 32'h55, 0, 3);
        issue(0, 0, 1, 1032, 32'hDEAD_BEEF, 0);
        issue(1, 1, 0, 1036, 0, 5);
        issue(0, 0, 1, 1024, 32'hCAFE_F00D, 0);
        issue(1, 1, 0, 1024, 0, 6);
        issue(0, 0, 1, 1026, 32'h0BAD_0BAD, 0);
        issue(1, 1, 0, 1024, 0, 7);
        issue(1, 1, 0, 1030, 0, 8);
        issue(1, 1, 1, 1040, 32'h7777_1111, 9);
        issue(1, 1, 0, 1040, 0, 10);
        issue(1, 1, 0, 500, 0, 11);

        for (int n = 0; n < 300; n++) begin
            int unsigned k = $urandom_range(0, 3);
            logic [31:0] a = BASE + 4 * $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) a = a + $urandom_range(1, 3);
            if ($urandom_range(0, 15) == 0) a = $urandom_range(0, 1023);
            issue(1'($urandom), k == 1 || k == 3, k >= 2, (k == 0) ? $urandom : a, $urandom, 4'($urandom));
        end
        finish_seq();

        // Abandon a load two cycles into BUSY
        @(posedge clk);
        #1;
        drive(1, 0, 0, 32'hABCD, 0, 9);
        @(posedge clk);
        #1;
        drive(1, 1, 0, 1036, 0, 2);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_sram_en", ifc.sram_en, 0);
        chk("midrst_freeze", ifc.freeze, 0);
        chk("midrst_outputs", {ifc.wb_en, ifc.mem_r_en, ifc.alu_result, ifc.mem_data, ifc.dest, ifc.align_err, ifc.sram_we}, 0);
        ref_md = '0;
        ref_align = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", {ifc.sram_en, ifc.freeze}, 0);
        issue(1, 1, 0, 1036, 0, 4);
        finish_seq();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
